// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the modular exponentiation engine.
// Holds the FSM state encoding and the cycle-count model used to plan around the engine.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReduce,
        StMul,
        StSqr,
        StFin
    } state_e;

    localparam int unsigned MAX_WIDTH = 1024;

    // One modmul sub-op: a load cycle followed by one step per operand bit.
    function automatic int unsigned mul_cycles(input int unsigned width);
        return width + 1;
    endfunction

    // Cycles from the accepting edge to the cycle in which done is high (non-zero modulus).
    function automatic int unsigned exp_latency(input logic [MAX_WIDTH-1:0] e,
                                                input int unsigned width);
        int unsigned pop;
        int unsigned len;
        pop = 0;
        len = 0;
        for (int unsigned i = 0; i < width && i < MAX_WIDTH; i++) begin
            if (e[i]) begin
                pop = pop + 1;
                len = i + 1;
            end
        end
        return 1 + (1 + pop + ((len > 0) ? len - 1 : 0)) * mul_cycles(width);
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: p = a*b mod m, MSB-first interleaved shift-add.
// Takes one load cycle plus WIDTH step cycles; done/p are valid during the final step cycle.
module mod_mul_serial
    import mod_exp_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned MUL_CYCLES = mul_cycles(WIDTH);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MUL_CYCLES - 1);

    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH+1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH+1:0] m_ext, sum, sub1, sub2;

    // acc < m on entry and b <= m, so 2*acc + b < 3m: two subtractions fully reduce it.
    always_comb begin
        b_sel = a_q[WIDTH-1] ? b_q : '0;
        m_ext = {2'b00, m_q};
        sum   = (acc_q << 1) + {2'b00, b_sel};
        sub1  = (sum >= m_ext) ? sum - m_ext : sum;
        sub2  = (sub1 >= m_ext) ? sub1 - m_ext : sub1;
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LastCnt);
    assign p    = sub2[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load) begin
            a_q    <= a;
            b_q    <= b;
            m_q    <= m;
            acc_q  <= '0;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q   <= a_q << 1;
            acc_q <= sub2;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: result = base^exponent mod modulus, right-to-left binary method.
// Sequences a single serial modmul through REDUCE, MUL and SQR phases with a start/busy/done handshake.
module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] k_q, k_d, k_inc;

    logic             mm_load, mm_busy, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    logic             branch;
    logic [WIDTH-1:0] exp_rest;

    mod_mul_serial #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mm_load),
        .a     (mm_a),
        .b     (mm_b),
        .m     (mod_q),
        .busy  (mm_busy),
        .done  (mm_done),
        .p     (mm_p)
    );

    assign k_inc = k_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        b_d      = b_q;
        r_d      = r_q;
        k_d      = k_q;
        result_d = result_q;
        error_d  = error_q;
        mm_load  = 1'b0;
        mm_a     = b_q;
        mm_b     = b_q;
        branch   = 1'b0;
        exp_rest = '0;

        unique case (state_q)
            // The done cycle (StFin) accepts a new start exactly like StIdle.
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    base_d = base;
                    exp_d  = exponent;
                    mod_d  = modulus;
                    k_d    = '0;
                    if (modulus == '0) begin
                        state_d  = StFin;
                        result_d = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d = StReduce;
                        error_d = 1'b0;
                    end
                end
            end
            StReduce: begin
                mm_a    = base_q;
                mm_b    = WIDTH'(1);
                mm_load = !mm_busy;
                if (mm_done) begin
                    b_d      = mm_p;
                    r_d      = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    k_d      = '0;
                    exp_rest = exp_q;
                    branch   = 1'b1;
                end
            end
            StMul: begin
                mm_a    = r_q;
                mm_b    = b_q;
                mm_load = !mm_busy;
                if (mm_done) begin
                    r_d = mm_p;
                    if ((exp_q >> k_inc) == '0) begin
                        state_d  = StFin;
                        result_d = mm_p;
                    end else begin
                        state_d = StSqr;
                    end
                end
            end
            StSqr: begin
                mm_load = !mm_busy;
                if (mm_done) begin
                    b_d      = mm_p;
                    k_d      = k_inc;
                    exp_rest = exp_q >> k_inc;
                    branch   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pick the next phase from the exponent bits not yet consumed.
        if (branch) begin
            if (exp_rest == '0) begin
                state_d  = StFin;
                result_d = r_d;
            end else if (exp_rest[0]) begin
                state_d = StMul;
            end else begin
                state_d = StSqr;
            end
        end
    end

    assign busy   = (state_q == StReduce) || (state_q == StMul) || (state_q == StSqr);
    assign done   = (state_q == StFin);
    assign result = result_q;
    assign error  = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            b_q      <= '0;
            r_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            b_q      <= b_d;
            r_q      <= r_d;
            k_q      <= k_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: a 16-bit and a 128-bit instance checked against a
// plain square-and-multiply reference model, including done timing and busy duration.
module tb_mod_exp_engine;

    localparam int unsigned W  = 16;
    localparam int unsigned WB = 128;

    typedef struct {
        logic [127:0] res;
        logic         err;
        int unsigned  done_cyc;
        int unsigned  busy_n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic          start16, busy16, done16, error16;
    logic [W-1:0]  base16, exp16, mod16, result16;
    logic          start128, busy128, done128, error128;
    logic [WB-1:0] base128, exp128, mod128, result128;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t sb16[$];
    exp_t sb128[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_exp_engine #(.WIDTH(W)) u_dut16 (
        .clk      (clk),
        .reset    (reset),
        .start    (start16),
        .base     (base16),
        .exponent (exp16),
        .modulus  (mod16),
        .busy     (busy16),
        .done     (done16),
        .result   (result16),
        .error    (error16)
    );

    mod_exp_engine #(.WIDTH(WB)) u_dut128 (
        .clk      (clk),
        .reset    (reset),
        .start    (start128),
        .base     (base128),
        .exponent (exp128),
        .modulus  (mod128),
        .busy     (busy128),
        .done     (done128),
        .result   (result128),
        .error    (error128)
    );

    function automatic logic [127:0] ref_modexp(input logic [127:0] b, e, m);
        logic [255:0] r, x, mm;
        if (m == '0) return '0;
        mm = {128'd0, m};
        r  = 256'd1 % mm;
        x  = {128'd0, b} % mm;
        for (int i = 0; i < 128; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[127:0];
    endfunction

    // Sub-op count: one reduction, one multiply per set bit, one square per bit below the MSB.
    function automatic int unsigned ref_steps(input logic [127:0] e);
        int unsigned n;
        bit seen;
        n = 1;
        seen = 1'b0;
        for (int i = 127; i >= 0; i--) begin
            if (seen) n++;
            if (e[i]) begin
                n++;
                seen = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic expect_op(input bit big, input logic [127:0] b, e, m, input int unsigned t);
        exp_t x;
        int unsigned w;
        w = big ? WB : W;
        x.err = (m == '0);
        x.res = ref_modexp(b, e, m);
        if (x.err) begin
            x.busy_n   = 0;
            x.done_cyc = t + 1;
        end else begin
            x.busy_n   = ref_steps(e) * (w + 1);
            x.done_cyc = t + 1 + x.busy_n;
        end
        if (big) sb128.push_back(x);
        else sb16.push_back(x);
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue16(input logic [W-1:0] b, e, m);
        int unsigned g;
        g = 0;
        while (busy16 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (busy16) begin
            chk("issue16_wait_idle", 128'(busy16), 128'd0);
            return;
        end
        base16  = b;
        exp16   = e;
        mod16   = m;
        start16 = 1'b1;
        expect_op(1'b0, 128'(b), 128'(e), 128'(m), cyc);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic issue128(input logic [WB-1:0] b, e, m);
        int unsigned g;
        g = 0;
        while (busy128 && g < 40000) begin
            @(negedge clk);
            g++;
        end
        if (busy128) begin
            chk("issue128_wait_idle", 128'(busy128), 128'd0);
            return;
        end
        base128  = b;
        exp128   = e;
        mod128   = m;
        start128 = 1'b1;
        expect_op(1'b1, b, e, m, cyc);
        @(negedge clk);
        start128 = 1'b0;
    endtask

    task automatic wait_done16();
        int unsigned g;
        g = 0;
        while (!done16 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("wait16_done", 128'(done16), 128'd1);
    endtask

    // Start while busy must be ignored.
    task automatic poke16();
        start16 = 1'b1;
        base16  = 16'($urandom);
        exp16   = 16'($urandom);
        mod16   = 16'($urandom);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    initial begin : mon16
        exp_t x;
        int unsigned busy_run;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
            end else begin
                if (busy16) busy_run++;
                if (done16) begin
                    if (sb16.size() == 0) begin
                        chk("done16_spurious", 128'(done16), 128'd0);
                    end else begin
                        x = sb16.pop_front();
                        chk("result16", 128'(result16), x.res);
                        chk("error16", 128'(error16), 128'(x.err));
                        chk("done16_cycle", 128'(cyc), 128'(x.done_cyc));
                        chk("busy16_cycles", 128'(busy_run), 128'(x.busy_n));
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin : mon128
        exp_t x;
        int unsigned busy_run;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
            end else begin
                if (busy128) busy_run++;
                if (done128) begin
                    if (sb128.size() == 0) begin
                        chk("done128_spurious", 128'(done128), 128'd0);
                    end else begin
                        x = sb128.pop_front();
                        chk("result128", result128, x.res);
                        chk("error128", 128'(error128), 128'(x.err));
                        chk("done128_cycle", 128'(cyc), 128'(x.done_cyc));
                        chk("busy128_cycles", 128'(busy_run), 128'(x.busy_n));
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin : stim
        int unsigned g;
        logic [W-1:0] rb, re, rm;
        reset    = 1'b1;
        start16  = 1'b0;
        base16   = '0;
        exp16    = '0;
        mod16    = '0;
        start128 = 1'b0;
        base128  = '0;
        exp128   = '0;
        mod128   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy16), 128'd0);
        chk("reset_done", 128'(done16), 128'd0);
        chk("reset_result", 128'(result16), 128'd0);
        chk("reset_error", 128'(error16), 128'd0);
        reset = 1'b0;

        issue16(16'd4, 16'd13, 16'd497);
        wait_done16();
        issue16(16'd65, 16'd17, 16'd3233);
        wait_done16();
        issue16(16'd2790, 16'd2753, 16'd3233);
        wait_done16();

        // Edge cases, some issued back-to-back into the done cycle of the previous one.
        issue16(16'd9, 16'd5, 16'd0);
        issue16(16'd5, 16'd3, 16'd1);
        issue16(16'd9, 16'd0, 16'd7);
        issue16(16'd1000, 16'd1, 16'd7);
        issue16(16'hFFFF, 16'hFFFF, 16'hFFF1);
        wait_done16();

        issue16(16'd123, 16'h00F3, 16'd1009);
        repeat (20) @(negedge clk);
        poke16();
        repeat (30) @(negedge clk);
        poke16();
        wait_done16();
        issue16(16'd77, 16'd5, 16'd101);
        wait_done16();

        // Reset in the middle of the first squaring of 4^13 mod 497.
        issue16(16'd4, 16'd13, 16'd497);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        sb16.delete();
        @(negedge clk);
        chk("midreset_busy", 128'(busy16), 128'd0);
        chk("midreset_done", 128'(done16), 128'd0);
        chk("midreset_result", 128'(result16), 128'd0);
        reset = 1'b0;
        issue16(16'd4, 16'd13, 16'd497);
        wait_done16();

        for (int i = 0; i < 25; i++) begin
            rb = 16'($urandom);
            re = 16'($urandom) >> $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0: rm = 16'd0;
                1: rm = 16'd1;
                2: rm = 16'($urandom_range(2, 40));
                default: rm = 16'($urandom);
            endcase
            issue16(rb, re, rm);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                if (busy16) poke16();
            end
        end

        issue128(128'd3, 128'h1FFF_FFFF_FFFF_FFFE, 128'h1FFF_FFFF_FFFF_FFFF);
        issue128({$urandom(), $urandom(), $urandom(), $urandom()}, 128'($urandom_range(1, 31)),
                 {$urandom(), $urandom(), $urandom(), $urandom()} | 128'd1);
        issue128(128'd7, 128'd7, 128'd0);

        g = 0;
        while ((sb16.size() != 0 || sb128.size() != 0) && g < 60000) begin
            @(negedge clk);
            g++;
        end
        chk("drain16", 128'(sb16.size()), 128'd0);
        chk("drain128", 128'(sb128.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
Name: mod_exp_engine

Overview:
Parametrised modular exponentiation engine. It computes result = base^exponent mod modulus. It is the successor to the fixed-width exponentiation path inside the RSA control block, generalised to any WIDTH. It adds a start/busy/done handshake, early termination on exponent leading zeros, modulus==0 error reporting, and deterministic latency. The RSA control layer instantiates one engine for encryption and one for decryption, or shares a single engine between both.

Parameters:
WIDTH, 128, bit width of base, exponent, modulus and result.
CNT_W, $clog2(WIDTH+1), width of internal bit and step counters.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
base  input  WIDTH  operand, latched on accepted start.
exponent  input  WIDTH  operand, latched on accepted start.
modulus  input  WIDTH  operand, latched on accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when result/error are valid.
result  output  WIDTH  base^exponent mod modulus; held until next accepted start.
error  output  1  modulus==0 for the last operation; held like result.

Behaviour:
- Reset (any state, including mid-operation): the next edge forces state=IDLE, busy=0, done=0, result=0, error=0, and clears the sub-module.
- Accept: in IDLE with start=1, latch the operands. start while busy is ignored with no side effects. Back-to-back start in the done cycle is accepted, since the FSM is then in IDLE.
- Modmul sub-op: MSB-first interleaved shift-add. acc <= 2*acc + (a[i] ? b : 0), then up to two conditional subtractions of m. The internal accumulator is WIDTH+2 bits. Each sub-op takes exactly WIDTH+1 cycles (1 load, then WIDTH steps). Inputs satisfy a,b < m except in REDUCE.
- FSM states: IDLE, REDUCE, MUL, SQR, FIN.
  - IDLE -> FIN if modulus==0: error=1, result=0.
  - IDLE -> REDUCE otherwise.
  - REDUCE: b_reg = modmul(base, 1); r_reg = (modulus==1) ? 0 : 1; bit index k=0.
  - After REDUCE, or after each SQR: if exponent>>k == 0 -> FIN. Else if exponent[k] -> MUL. Else -> SQR.
  - MUL: r_reg = modmul(r_reg, b_reg). Then, if exponent>>(k+1) == 0 -> FIN; else -> SQR.
  - SQR: b_reg = modmul(b_reg, b_reg); k=k+1.
  - FIN: done=1 for one cycle, result=r_reg, busy=0, -> IDLE.
- Latency: start accepted at edge t means done is high in cycle t+1+N*(WIDTH+1).
  - N = 1 + popcount(e) + max(bitlen(e)-1, 0).
  - Modulus==0 gives done at t+1.
  - e==0 gives N=1 and result = 1 mod m.
- Boundaries:
  - base >= modulus is handled by REDUCE.
  - modulus==1 gives result 0.
  - exponent all-ones gives maximum N = 2*WIDTH.
  - No arithmetic overflow for any WIDTH >= 2.

Decomposition:
- Package mod_exp_pkg:
  - FSM state enum.
  - Function exp_latency(e, WIDTH) for the bench.
  - Localparam MUL_CYCLES = WIDTH+1.
- One sub-module, mod_mul_serial (WIDTH):
  - Ports: clk, reset, load, a, b, m, busy, done, p.
  - Owns the accumulator and the step counter.
  - The top FSM only sequences it.

Test Plan:
1. WIDTH=16: base=4, exponent=13, modulus=497 -> result=445, error=0, done in cycle t+120 (N=7), busy high for exactly 119 cycles.
2. WIDTH=16 RSA round trip: base=65, e=17, m=3233 -> 2790. Then base=2790, e=2753, m=3233 -> 65. Both done pulses are one cycle wide.
3. WIDTH=128 Fermat check: base=3, exponent=2^61-2, modulus=2^61-1 -> result=1. Latency matches exp_latency.
4. Edge cases, WIDTH=16:
   - modulus=0 -> error=1, result=0, done at t+1.
   - modulus=1, base=5, e=3 -> result=0.
   - e=0, base=9, m=7 -> result=1 after N=1.
   - base=1000, e=1, m=7 -> result=6.
5. Handshake: start re-asserted while busy -> ignored and result unchanged. start asserted in the done cycle -> the new operation is accepted.
6. Reset mid-operation: assert reset during SQR of test 1 -> the following cycle shows busy=0, done=0, result=0. A fresh start then reproduces 445.
